data_inf_rr_merge: RTL and testbench

- Parametrised N-to-1 merge of valid/ready data channels with round-robin arbitration and a registered output stage.
- Generalises the single fixed-width data-interface register to NUM channels, any DSIZE, and an optional packet-lock mode.
- Sits between per-lane producers (e.g. an array of 8-bit data channels) and one shared downstream consumer.
- Tags each output beat with its source channel id.

---
 rtl/data_inf_rr_merge.sv | 92 +++++++++
 tb/tb_data_inf_rr_merge.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_inf_rr_merge.sv
// N-to-1 valid/ready merge with round-robin arbitration, optional packet lock,
// and a single registered output stage tagged with the source channel id.
module data_inf_rr_merge #(
  parameter int NUM      = 4,
  parameter int DSIZE    = 8,
  parameter int PKT_MODE = 0,
  localparam int IDW     = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [NUM-1:0]        s_valid,
  input  logic [NUM*DSIZE-1:0]  s_data,
  input  logic [NUM-1:0]        s_last,
  output logic [NUM-1:0]        s_ready,
  output logic                  m_valid,
  output logic [DSIZE-1:0]      m_data,
  output logic                  m_last,
  output logic [IDW-1:0]        m_id,
  input  logic                  m_ready
);

  typedef enum logic {IDLE, LOCKED} lock_e;

  lock_e                        state_q;
  logic [IDW-1:0]               lock_id_q, ptr_q, ptr_d;
  logic                         m_valid_q, m_last_q;
  logic [DSIZE-1:0]             m_data_q;
  logic [IDW-1:0]               m_id_q;
  logic [NUM-1:0][DSIZE-1:0]    lane_data;
  logic [IDW-1:0]               gnt, cand;
  logic                         gnt_vld, accept, take;

  assign lane_data = s_data;
  assign accept    = !m_valid_q || m_ready;
  assign take      = accept && gnt_vld && !rst;

  // Walk the rotation from the far end so the channel nearest ptr wins.
  always_comb begin
    gnt     = ptr_q;
    gnt_vld = 1'b0;
    cand    = '0;
    if (PKT_MODE != 0 && state_q == LOCKED) begin
      gnt     = lock_id_q;
      gnt_vld = s_valid[lock_id_q];
    end else begin
      for (int k = NUM-1; k >= 0; k--) begin
        cand = IDW'((int'(ptr_q) + k) % NUM);
        if (s_valid[cand]) begin
          gnt     = cand;
          gnt_vld = 1'b1;
        end
      end
    end
  end

  assign ptr_d = (gnt == IDW'(NUM-1)) ? '0 : gnt + 1'b1;

  for (genvar i = 0; i < NUM; i++) begin : g_rdy
    assign s_ready[i] = take && (gnt == IDW'(i));
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
      ptr_q     <= '0;
      lock_id_q <= '0;
      state_q   <= IDLE;
    end else if (take) begin
      m_valid_q <= 1'b1;
      m_data_q  <= lane_data[gnt];
      m_last_q  <= s_last[gnt];
      m_id_q    <= gnt;
      ptr_q     <= ptr_d;
      // Lock opens on a non-last beat and closes on the accepted last beat.
      if (PKT_MODE != 0) begin
        state_q   <= s_last[gnt] ? IDLE : LOCKED;
        lock_id_q <= gnt;
      end
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_id    = m_id_q;

endmodule

// File: tb/tb_data_inf_rr_merge.sv
// Random-stimulus scoreboard bench for data_inf_rr_merge; two instances cover
// per-beat arbitration (index 0) and packet-lock mode (index 1) side by side.
module tb_data_inf_rr_merge;
  localparam int NUM   = 4;
  localparam int DSIZE = 8;
  localparam int IDW   = 2;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [DSIZE-1:0] data;
    logic             last;
  } beat_t;

  logic                       clock, rst;
  logic [1:0][NUM-1:0]        s_valid, s_last, s_ready;
  logic [1:0][NUM*DSIZE-1:0]  s_data;
  logic [1:0]                 m_valid, m_last, m_ready;
  logic [1:0][DSIZE-1:0]      m_data;
  logic [1:0][IDW-1:0]        m_id;

  data_inf_rr_merge #(.NUM(NUM), .DSIZE(DSIZE), .PKT_MODE(0)) dut0 (
    .clock(clock), .rst(rst), .s_valid(s_valid[0]), .s_data(s_data[0]),
    .s_last(s_last[0]), .s_ready(s_ready[0]), .m_valid(m_valid[0]),
    .m_data(m_data[0]), .m_last(m_last[0]), .m_id(m_id[0]), .m_ready(m_ready[0]));

  data_inf_rr_merge #(.NUM(NUM), .DSIZE(DSIZE), .PKT_MODE(1)) dut1 (
    .clock(clock), .rst(rst), .s_valid(s_valid[1]), .s_data(s_data[1]),
    .s_last(s_last[1]), .s_ready(s_ready[1]), .m_valid(m_valid[1]),
    .m_data(m_data[1]), .m_last(m_last[1]), .m_id(m_id[1]), .m_ready(m_ready[1]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0, fails = 0;

  // Reference model state: rotation pointer, packet lock, output occupancy.
  int             mptr [2];
  bit             mlock[2];
  int             mlid [2];
  bit             mocc [2];
  bit             rstp [2];
  logic [NUM-1:0] acc  [2];
  beat_t          q0[$], q1[$];

  task automatic push(input int d, input beat_t b);
    if (d == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic step(input int d);
    bit accept, ok;
    int g;
    logic [NUM-1:0] exp_rdy;
    beat_t b;
    if (rst) begin
      tests++;
      if (s_ready[d] !== '0) begin
        fails++; $display("FAIL rst_ready d%0d: got %b want 0000", d, s_ready[d]);
      end
      mptr[d] = 0; mlock[d] = 0; mlid[d] = 0; mocc[d] = 0; rstp[d] = 1;
      if (d == 0) q0.delete(); else q1.delete();
      return;
    end
    if (rstp[d]) begin
      tests++;
      if (m_valid[d] !== 1'b0 || m_id[d] !== '0 || m_data[d] !== '0 || m_last[d] !== 1'b0) begin
        fails++;
        $display("FAIL post_rst d%0d: got v=%b id=%0d data=%h last=%b want all zero",
                 d, m_valid[d], m_id[d], m_data[d], m_last[d]);
      end
      rstp[d] = 0;
    end
    tests++;
    if (m_valid[d] !== mocc[d]) begin
      fails++; $display("FAIL m_valid d%0d: got %b want %b", d, m_valid[d], mocc[d]);
    end
    accept = !mocc[d] || m_ready[d];
    ok = 0; g = 0;
    if (d == 1 && mlock[d]) begin
      g = mlid[d]; ok = s_valid[d][g];
    end else begin
      for (int k = 0; k < NUM; k++) begin
        if (!ok && s_valid[d][(mptr[d] + k) % NUM]) begin
          g = (mptr[d] + k) % NUM; ok = 1;
        end
      end
    end
    exp_rdy = (accept && ok) ? NUM'(1 << g) : '0;
    tests++;
    if (s_ready[d] !== exp_rdy) begin
      fails++; $display("FAIL s_ready d%0d: got %b want %b", d, s_ready[d], exp_rdy);
    end
    if (accept && ok) begin
      b.id = IDW'(g); b.data = s_data[d][g*DSIZE +: DSIZE]; b.last = s_last[d][g];
      push(d, b);
      acc[d][g] = 1'b1;
      mptr[d] = (g + 1) % NUM;
      if (d == 1) begin mlock[d] = !s_last[d][g]; mlid[d] = g; end
      mocc[d] = 1;
    end else if (m_ready[d]) begin
      mocc[d] = 0;
    end
  endtask

  // Sources keep a beat asserted until it is accepted, then maybe offer a new one.
  task automatic cycle(input bit r, input int pv, input int pr);
    @(negedge clock);
    rst = r;
    for (int d = 0; d < 2; d++) begin
      m_ready[d] = ($urandom % 100) < pr;
      for (int c = 0; c < NUM; c++) begin
        if (!s_valid[d][c] || acc[d][c]) begin
          s_valid[d][c] = ($urandom % 100) < pv;
          s_data[d][c*DSIZE +: DSIZE] = DSIZE'($urandom);
          s_last[d][c] = ($urandom % 3) == 0;
        end
      end
      acc[d] = '0;
    end
    #1;
    for (int d = 0; d < 2; d++) step(d);
  endtask

  // Monitor: every beat leaving an output must match the oldest predicted beat.
  initial begin
    beat_t e, a;
    forever begin
      @(negedge clock);
      #3;
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          if (m_valid[d] && m_ready[d]) begin
            a.id = m_id[d]; a.data = m_data[d]; a.last = m_last[d];
            tests++;
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
              fails++; $display("FAIL spurious_beat d%0d: got id=%0d data=%h want none", d, a.id, a.data);
            end else begin
              e = (d == 0) ? q0.pop_front() : q1.pop_front();
              if (a !== e) begin
                fails++;
                $display("FAIL beat d%0d: got id=%0d data=%h last=%b want id=%0d data=%h last=%b",
                         d, a.id, a.data, a.last, e.id, e.data, e.last);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    s_valid = '0; s_last = '0; s_data = '0; m_ready = '1;
    for (int d = 0; d < 2; d++) begin
      acc[d] = '0; mptr[d] = 0; mlock[d] = 0; mlid[d] = 0; mocc[d] = 0; rstp[d] = 0;
    end
    repeat (2)   cycle(1'b1, 100, 100);
    repeat (16)  cycle(1'b0, 100, 100);
    repeat (400) cycle(1'b0, 60, 70);
    repeat (400) cycle(1'b0, 30, 50);
    repeat (2)   cycle(1'b1, 60, 70);
    repeat (400) cycle(1'b0, 80, 40);
    repeat (12)  cycle(1'b0, 0, 100);
    @(negedge clock);
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++; $display("FAIL drain: got %0d/%0d pending beats want 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
